// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and the default address width.
package fifo_pkg;

  localparam int unsigned FIFO_ADDRSIZE = 4;
  localparam int unsigned PtrMaxW       = 32;

  typedef logic [PtrMaxW-1:0] ptr_max_t;

  // Width-agnostic: zero-extend narrower pointers in and truncate the result out.
  // Leading zeros leave the low bits of the prefix XOR unchanged.
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PtrMaxW-1] = g[PtrMaxW-1];
    for (int i = PtrMaxW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/wfifo_level_if.sv
// Signal bundle between the write-side FIFO logic and the level block.
interface wfifo_level_if #(
  parameter int unsigned ADDRSIZE = 4
);
  logic [ADDRSIZE:0] rptr;
  logic [ADDRSIZE:0] wptr;
  logic              winc;
  logic              wfull;
  logic [ADDRSIZE:0] afull_thresh;
  logic              err_clr;
  logic [ADDRSIZE:0] wq2_rptr;
  logic [ADDRSIZE:0] wcount;
  logic              walmost_full;
  logic              wovf;
  logic              wcount_err;

  modport master (
    output rptr, wptr, winc, wfull, afull_thresh, err_clr,
    input  wq2_rptr, wcount, walmost_full, wovf, wcount_err
  );

  modport slave (
    input  rptr, wptr, winc, wfull, afull_thresh, err_clr,
    output wq2_rptr, wcount, walmost_full, wovf, wcount_err
  );
endinterface

// File: rtl/ptr_sync.sv
// Generic N-stage flop-chain synchronizer for Gray pointers crossing clock domains.
module ptr_sync #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/wfifo_level.sv
// Write-domain fill level: syncs the read pointer, decodes both pointers, registers level/flags.
module wfifo_level
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE    = FIFO_ADDRSIZE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic          wclk,
  input logic          wrst_n,
  wfifo_level_if.slave bus
);

  localparam int unsigned PtrW = ADDRSIZE + 1;
  localparam logic [PtrW-1:0] Depth = PtrW'(1) << ADDRSIZE;

  logic [PtrW-1:0] wq2_rptr;
  logic [PtrW-1:0] rbin;
  logic [PtrW-1:0] wbin;
  logic [PtrW-1:0] diff;

  logic [PtrW-1:0] wcount_d, wcount_q;
  logic            walmost_full_d, walmost_full_q;
  logic            wovf_d, wovf_q;
  logic            wcount_err_d, wcount_err_q;

  ptr_sync #(
    .WIDTH  (PtrW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (bus.rptr),
    .q     (wq2_rptr)
  );

  assign rbin = PtrW'(gray2bin(ptr_max_t'(wq2_rptr)));
  assign wbin = PtrW'(gray2bin(ptr_max_t'(bus.wptr)));

  always_comb begin
    // Modular subtraction at full pointer width absorbs pointer wrap.
    diff           = wbin - rbin;
    wcount_d       = diff;
    walmost_full_d = (diff >= bus.afull_thresh);
    // Set dominates clear so an event coinciding with err_clr is never lost.
    wovf_d         = (bus.winc & bus.wfull) | (wovf_q & ~bus.err_clr);
    wcount_err_d   = (diff > Depth) | (wcount_err_q & ~bus.err_clr);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wcount_q       <= '0;
      walmost_full_q <= 1'b0;
      wovf_q         <= 1'b0;
      wcount_err_q   <= 1'b0;
    end else begin
      wcount_q       <= wcount_d;
      walmost_full_q <= walmost_full_d;
      wovf_q         <= wovf_d;
      wcount_err_q   <= wcount_err_d;
    end
  end

  assign bus.wq2_rptr     = wq2_rptr;
  assign bus.wcount       = wcount_q;
  assign bus.walmost_full = walmost_full_q;
  assign bus.wovf         = wovf_q;
  assign bus.wcount_err   = wcount_err_q;

endmodule

// File: tb/tb_wfifo_level.sv
// Bench for wfifo_level: directed plan steps plus random traffic against a latency/level model.
module tb_wfifo_level;

  localparam int unsigned A    = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DEP  = 1 << A;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [A:0] rpipe[$];
  logic [A:0] m_wq2;
  logic [A:0] m_cnt;
  logic       m_af;
  logic       m_ovf;
  logic       m_err;

  wfifo_level_if #(.ADDRSIZE(A)) bus ();

  wfifo_level #(
    .ADDRSIZE    (A),
    .SYNC_STAGES (SYNC)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus.slave)
  );

  always #5 wclk = ~wclk;

  function automatic logic [A:0] g2b(input logic [A:0] g);
    logic [A:0] b = g;
    for (int s = 1; s <= A; s++) b ^= g >> s;
    return b;
  endfunction

  function automatic logic [A:0] b2g(input logic [A:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rpipe.delete();
    for (int i = 0; i < SYNC - 1; i++) rpipe.push_back('0);
    m_wq2 = '0; m_cnt = '0; m_af = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
  endtask

  // One wclk edge: update the model from the inputs seen at the edge, then compare.
  task automatic tick();
    logic [A:0] wq2_before;
    int         lvl;
    @(posedge wclk);
    wq2_before = m_wq2;
    rpipe.push_back(bus.rptr);
    m_wq2 = rpipe.pop_front();
    lvl   = (int'(g2b(bus.wptr)) - int'(g2b(wq2_before)) + 2 * DEP) % (2 * DEP);
    m_cnt = lvl[A:0];
    m_af  = (lvl >= int'(bus.afull_thresh));
    m_ovf = (bus.winc & bus.wfull) | (m_ovf & ~bus.err_clr);
    m_err = (lvl > DEP) | (m_err & ~bus.err_clr);
    #1;
    check("m_wq2_rptr", 32'(bus.wq2_rptr), 32'(m_wq2));
    check("m_wcount", 32'(bus.wcount), 32'(m_cnt));
    check("m_walmost_full", 32'(bus.walmost_full), 32'(m_af));
    check("m_wovf", 32'(bus.wovf), 32'(m_ovf));
    check("m_wcount_err", 32'(bus.wcount_err), 32'(m_err));
  endtask

  initial begin
    bus.rptr = '0; bus.wptr = 5'b00111; bus.winc = 1'b0; bus.wfull = 1'b0;
    bus.afull_thresh = 5'd31; bus.err_clr = 1'b0;
    model_reset();

    // Reset state
    #12;
    check("rst_wq2_rptr", 32'(bus.wq2_rptr), 0);
    check("rst_wcount", 32'(bus.wcount), 0);
    check("rst_walmost_full", 32'(bus.walmost_full), 0);
    check("rst_wovf", 32'(bus.wovf), 0);
    check("rst_wcount_err", 32'(bus.wcount_err), 0);
    @(negedge wclk);
    wrst_n = 1'b1;
    tick();
    tick();
    check("post_rst_wq2", 32'(bus.wq2_rptr), 0);
    check("post_rst_wcount", 32'(bus.wcount), 5);
    check("post_rst_wovf", 32'(bus.wovf), 0);
    check("post_rst_err", 32'(bus.wcount_err), 0);

    // rptr sync latency
    bus.rptr = 5'b00011;
    tick();
    check("sync_e1_wq2", 32'(bus.wq2_rptr), 0);
    check("sync_e1_wcount", 32'(bus.wcount), 5);
    tick();
    check("sync_e2_wq2", 32'(bus.wq2_rptr), 32'b00011);
    check("sync_e2_wcount", 32'(bus.wcount), 5);
    tick();
    check("sync_e3_wcount", 32'(bus.wcount), 3);

    // Wrap-around
    bus.wptr = 5'b00011; bus.rptr = 5'b10010;
    repeat (3) tick();
    check("wrap_wcount", 32'(bus.wcount), 6);
    check("wrap_err", 32'(bus.wcount_err), 0);

    // Almost-full
    bus.afull_thresh = 5'd12; bus.rptr = '0; bus.wptr = b2g(5'd10);
    repeat (3) tick();
    check("af10", 32'(bus.walmost_full), 0);
    check("af10_cnt", 32'(bus.wcount), 10);
    bus.wptr = b2g(5'd11);
    tick();
    check("af11", 32'(bus.walmost_full), 0);
    bus.wptr = b2g(5'd12);
    tick();
    check("af12", 32'(bus.walmost_full), 1);
    bus.wptr = b2g(5'd16);
    tick();
    check("af16", 32'(bus.walmost_full), 1);
    check("af16_cnt", 32'(bus.wcount), 16);

    // Overflow
    bus.winc = 1'b1; bus.wfull = 1'b1;
    tick();
    check("ovf_set", 32'(bus.wovf), 1);
    bus.winc = 1'b0; bus.wfull = 1'b0;
    tick();
    check("ovf_hold", 32'(bus.wovf), 1);
    bus.err_clr = 1'b1;
    tick();
    check("ovf_clr", 32'(bus.wovf), 0);
    bus.winc = 1'b1; bus.wfull = 1'b1;
    tick();
    check("ovf_set_wins", 32'(bus.wovf), 1);
    bus.winc = 1'b0; bus.wfull = 1'b0; bus.err_clr = 1'b0;
    tick();
    check("ovf_hold2", 32'(bus.wovf), 1);

    // Sanity error
    bus.wptr = 5'b11110; bus.rptr = '0;
    tick();
    check("err_cnt20", 32'(bus.wcount), 20);
    check("err_set", 32'(bus.wcount_err), 1);
    bus.wptr = b2g(5'd5);
    tick();
    check("err_sticky", 32'(bus.wcount_err), 1);
    check("err_cnt5", 32'(bus.wcount), 5);
    bus.err_clr = 1'b1;
    tick();
    check("err_clr", 32'(bus.wcount_err), 0);
    check("err_clr_ovf", 32'(bus.wovf), 0);
    bus.err_clr = 1'b0;

    // Threshold extremes
    bus.afull_thresh = 5'd0;
    tick();
    check("thr0_af", 32'(bus.walmost_full), 1);
    bus.afull_thresh = 5'd17; bus.wptr = b2g(5'd16);
    tick();
    check("thr17_af", 32'(bus.walmost_full), 0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus.rptr         = b2g(5'($urandom_range(0, 31)));
      bus.wptr         = b2g(5'($urandom_range(0, 31)));
      bus.winc         = 1'($urandom_range(0, 1));
      bus.wfull        = 1'($urandom_range(0, 3) == 0);
      bus.err_clr      = 1'($urandom_range(0, 7) == 0);
      bus.afull_thresh = 5'($urandom_range(0, 18));
      tick();
    end

    // Asynchronous reset mid-run
    #2;
    wrst_n = 1'b0;
    #1;
    check("rst2_wcount", 32'(bus.wcount), 0);
    check("rst2_wq2", 32'(bus.wq2_rptr), 0);
    check("rst2_flags", 32'({bus.wovf, bus.wcount_err, bus.walmost_full}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wfifo_level.md
Name: wfifo_level

Overview:
- Write-domain companion to the async FIFO write-pointer/full block, and the decoder for its binary-to-Gray encoder.
- Synchronizes the read-domain Gray read pointer into wclk, then decodes both the synchronized read pointer and the local Gray write pointer to binary.
- Produces a registered fill level, a programmable almost-full flag, a sticky overflow flag and a sticky pointer-sanity error.
- The synchronized pointer output wq2_rptr feeds the write-pointer/full block, so this block replaces the standalone read-to-write synchronizer.

Parameters:
- ADDRSIZE, 4: FIFO depth is 2^ADDRSIZE; pointers are ADDRSIZE+1 bits wide.
- SYNC_STAGES, 2: flop stages on rptr, legal values 2..4.

Ports:
- wclk  in  1  write clock.
- wrst_n  in  1  reset, asynchronous, active-low.
- rptr  in  ADDRSIZE+1  Gray read pointer, launched from the read clock domain (asynchronous to wclk).
- wptr  in  ADDRSIZE+1  Gray write pointer, registered in wclk domain.
- winc  in  1  write request, same signal the write-pointer/full block sees.
- wfull  in  1  registered full flag from the write-pointer/full block.
- afull_thresh  in  ADDRSIZE+1  almost-full threshold in words, quasi-static.
- err_clr  in  1  single-cycle clear for the sticky flags.
- wq2_rptr  out  ADDRSIZE+1  synchronized Gray read pointer.
- wcount  out  ADDRSIZE+1  fill level in words, 0..2^ADDRSIZE.
- walmost_full  out  1  high when wcount >= afull_thresh.
- wovf  out  1  sticky: a write was attempted while full.
- wcount_err  out  1  sticky: computed level exceeded 2^ADDRSIZE.

Behaviour:
- Reset (async assert, wclk-synchronous deassert handled upstream): all sync flops, wq2_rptr, wcount, walmost_full, wovf and wcount_err = 0.
- Synchronizer: rptr passes through a SYNC_STAGES-deep flop chain; wq2_rptr is the last stage. No logic sits between stages. An rptr change captured at edge k appears on wq2_rptr after edge k+SYNC_STAGES-1.
- Gray-to-binary decode, for both wq2_rptr and wptr:
  - b[ADDRSIZE] = g[ADDRSIZE];
  - b[i] = b[i+1] ^ g[i].
  - Purely combinational.
- Level computation: diff = (wbin - rbin) mod 2^(ADDRSIZE+1), computed at ADDRSIZE+1 bits so that pointer wrap is handled by modular arithmetic.
  - Registered: wcount <= diff each wclk edge.
  - A wptr change is visible in wcount one edge later.
  - A wq2_rptr change is visible in wcount one edge later.
- walmost_full <= (diff >= afull_thresh), registered on the same edge as wcount. Consequences:
  - afull_thresh = 0 gives walmost_full = 1 from the first edge after reset.
  - afull_thresh > 2^ADDRSIZE means walmost_full never asserts.
- wcount_err: set on any edge where diff > 2^ADDRSIZE; wcount still loads diff unclamped.
- wovf: set on any edge where winc & wfull.
- Sticky flags hold until an edge with err_clr = 1. If a set condition and err_clr occur on the same edge, set wins (flag stays 1).
- Level is pessimistic: the read pointer is stale by the sync latency, so wcount >= true occupancy. This is required for safe write-side flow control.
- No handshake and no state machine beyond the flop chains; the block runs continuously after reset.

Decomposition:
- Shared package (fifo_pkg):
  - gray2bin function, parameterised by width;
  - bin2gray function, shared with the write-pointer/full block;
  - FIFO_ADDRSIZE default constant.
- Sub-module ptr_sync:
  - generic N-stage synchronizer (WIDTH, STAGES parameters, clock, async active-low reset);
  - instantiated once here and reusable for the write-to-read direction.

Test Plan (ADDRSIZE=4, SYNC_STAGES=2, depth 16):
- Reset latency: reset, drive rptr=5'b00000 and wptr=5'b00111 (bin 5) -> wq2_rptr=0, wcount=5 by the second edge after reset release; wovf=0, wcount_err=0.
- rptr sync latency: hold wptr=bin 5, step rptr to Gray 5'b00011 (bin 2) -> wq2_rptr=5'b00011 after edge 2, wcount=3 after edge 3; no intermediate value.
- Wrap-around: wptr Gray 5'b00011 (bin 2), rptr Gray 5'b10010 (bin 28) -> wcount=6, wcount_err=0.
- Almost-full: afull_thresh=12, rptr=0, step wptr through bins 10, 11, 12, 16 -> walmost_full 0, 0, 1, 1 and wcount=16 at the end.
- Overflow: winc=1 with wfull=1 for one edge -> wovf=1 and stays 1. err_clr alone -> 0. err_clr together with winc & wfull -> stays 1.
- Sanity error: wptr Gray 5'b11110 (bin 20), rptr=0 -> wcount=20, wcount_err=1 (sticky). err_clr with a legal level -> 0.
